// File: rtl/sim_kuart_endpoint.sv
// -----------------------------------------------------------------------------
// sim_kuart_endpoint
//
// Byte-wide bridge between a CPU and a simulation-side "kuart" channel.
//
//   TX path : CPU writes bytes into a TX FIFO. An IDLE/GAP state machine emits
//             one byte at a time onto kuart_from_cpu with a single-cycle
//             kuart_from_cpu_valid pulse. After each emitted byte it waits
//             TX_GAP idle cycles before it emits the next one. A byte written
//             while the FIFO is empty and the engine is IDLE is forwarded on
//             the same edge, so its pulse appears on the following cycle.
//   RX path : simulation bytes are pushed into an RX FIFO whenever
//             kuart_to_cpu_valid && kuart_to_cpu_ready. The CPU reads the head
//             (first-word fall-through) and pops it with rx_re. A byte offered
//             while not ready is discarded and sets the sticky rx_dropped flag.
//
// Optional feature (macro KUART_ECHO_EN):
//   When defined, every accepted RX byte is also pushed into the TX FIFO.
//   kuart_to_cpu_ready then also requires room in the TX FIFO, and an echo
//   push takes the TX FIFO write port, so tx_ready is low in that cycle.
//
// Parameters:
//   TX_DEPTH  TX FIFO entries (power of two, 2..64)
//   RX_DEPTH  RX FIFO entries (power of two, 2..64)
//   TX_GAP    idle cycles between emitted TX bytes (0..255)
//
// Ports:
//   clk                   clock, rising edge
//   reset_n               asynchronous active-low reset
//   tx_data / tx_we       CPU byte and write strobe (accepted with tx_ready)
//   tx_ready              TX FIFO can accept a CPU byte this cycle
//   rx_data / rx_valid    RX FIFO head and non-empty flag
//   rx_re                 pop RX head (ignored when empty)
//   rx_dropped            sticky: a simulation byte was offered while not ready
//   kuart_from_cpu        last byte emitted toward the simulation
//   kuart_from_cpu_valid  one-cycle pulse per emitted byte
//   kuart_to_cpu          byte from the simulation
//   kuart_to_cpu_valid    simulation byte offered
//   kuart_to_cpu_ready    RX side can accept a byte this cycle
// -----------------------------------------------------------------------------
module sim_kuart_endpoint #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int TX_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_re,
  output logic       rx_dropped,
  output logic [7:0] kuart_from_cpu,
  output logic       kuart_from_cpu_valid,
  input  logic [7:0] kuart_to_cpu,
  input  logic       kuart_to_cpu_valid,
  output logic       kuart_to_cpu_ready
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  localparam logic [TAW:0]   TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0]   RX_FULL_CNT = (RAW+1)'(RX_DEPTH);
  localparam logic [TAW-1:0] TX_PTR_ONE  = TAW'(1);
  localparam logic [RAW-1:0] RX_PTR_ONE  = RAW'(1);
  localparam logic [TAW:0]   TX_CNT_ONE  = (TAW+1)'(1);
  localparam logic [RAW:0]   RX_CNT_ONE  = (RAW+1)'(1);
  localparam logic [7:0]     GAP_LOAD    = 8'(TX_GAP);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } tx_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  tx_state_e      state_q,     state_d;
  logic [7:0]     gap_cnt_q,   gap_cnt_d;
  logic [7:0]     from_cpu_q,  from_cpu_d;
  logic           from_vld_q,  from_vld_d;

  logic [TAW:0]   tx_cnt_q,    tx_cnt_d;
  logic [TAW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TAW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [7:0]     tx_mem_q [TX_DEPTH];

  logic [RAW:0]   rx_cnt_q,    rx_cnt_d;
  logic [RAW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RAW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic           dropped_q,   dropped_d;

  // ---------------------------------------------------------------------------
  // Handshake / flow control
  // ---------------------------------------------------------------------------
  logic       tx_not_full;
  logic       tx_empty;
  logic       rx_not_full;
  logic       echo_push;
  logic       tx_in_vld;
  logic [7:0] tx_in_byte;
  logic       rx_push;
  logic       rx_pop;

  assign tx_not_full = (tx_cnt_q != TX_FULL_CNT);
  assign tx_empty    = (tx_cnt_q == '0);
  assign rx_not_full = (rx_cnt_q != RX_FULL_CNT);

`ifdef KUART_ECHO_EN
  // An accepted RX byte must also fit into the TX FIFO.
  assign kuart_to_cpu_ready = rx_not_full && tx_not_full;
  assign echo_push          = kuart_to_cpu_valid && kuart_to_cpu_ready;
`else
  assign kuart_to_cpu_ready = rx_not_full;
  assign echo_push          = 1'b0;
`endif

  // The echo owns the TX write port in the cycle it pushes.
  assign tx_ready   = tx_not_full && !echo_push;
  assign tx_in_vld  = echo_push || (tx_we && tx_ready);
  assign tx_in_byte = echo_push ? kuart_to_cpu : tx_data;

  assign rx_push    = kuart_to_cpu_valid && kuart_to_cpu_ready;
  assign rx_valid   = (rx_cnt_q != '0);
  assign rx_pop     = rx_re && rx_valid;
  assign rx_data    = rx_mem_q[rx_rd_ptr_q];

  // ---------------------------------------------------------------------------
  // TX engine: output logic
  // ---------------------------------------------------------------------------
  logic       emit;
  logic       bypass;
  logic [7:0] emit_byte;
  logic       tx_push;
  logic       tx_pop;

  always_comb begin
    emit      = 1'b0;
    bypass    = 1'b0;
    emit_byte = tx_mem_q[tx_rd_ptr_q];
    if (state_q == ST_IDLE) begin
      if (!tx_empty) begin
        emit = 1'b1;
      end else if (tx_in_vld) begin
        // Empty FIFO: forward the incoming byte straight to the output
        // register instead of storing it, which gives one-cycle latency.
        emit      = 1'b1;
        bypass    = 1'b1;
        emit_byte = tx_in_byte;
      end
    end
  end

  assign tx_push = tx_in_vld && !bypass;
  assign tx_pop  = emit && !bypass;

  // ---------------------------------------------------------------------------
  // TX engine: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (emit && (TX_GAP != 0)) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 8'd1;
        if (gap_cnt_q == 8'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gap_cnt_d = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    from_cpu_d  = emit ? emit_byte : from_cpu_q;
    from_vld_d  = emit;

    tx_wr_ptr_d = tx_push ? (tx_wr_ptr_q + TX_PTR_ONE) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? (tx_rd_ptr_q + TX_PTR_ONE) : tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
    end

    rx_wr_ptr_d = rx_push ? (rx_wr_ptr_q + RX_PTR_ONE) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? (rx_rd_ptr_q + RX_PTR_ONE) : rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
    end

    dropped_d = dropped_q || (kuart_to_cpu_valid && !kuart_to_cpu_ready);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= 8'd0;
      from_cpu_q  <= 8'h00;
      from_vld_q  <= 1'b0;
      tx_cnt_q    <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      from_cpu_q  <= from_cpu_d;
      from_vld_q  <= from_vld_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      dropped_q   <= dropped_d;
    end
  end

  // FIFO storage carries no reset; the pointers/counts define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_ptr_q] <= tx_in_byte;
    end
    if (rx_push) begin
      rx_mem_q[rx_wr_ptr_q] <= kuart_to_cpu;
    end
  end

  assign kuart_from_cpu       = from_cpu_q;
  assign kuart_from_cpu_valid = from_vld_q;
  assign rx_dropped           = dropped_q;

endmodule

// File: tb/tb_sim_kuart_endpoint.sv
// -----------------------------------------------------------------------------
// Testbench for sim_kuart_endpoint (default parameters). A queue-based model
// of the endpoint is advanced once per cycle on the falling clock edge and
// every output is compared against it; directed sequences add literal
// expectations on top of that.
// -----------------------------------------------------------------------------
module tb_sim_kuart_endpoint;

  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 8;
  localparam int TX_GAP   = 4;

  logic       clk                = 1'b0;
  logic       reset_n            = 1'b1;
  logic [7:0] tx_data            = 8'h00;
  logic       tx_we              = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_re              = 1'b0;
  logic       rx_dropped;
  logic [7:0] kuart_from_cpu;
  logic       kuart_from_cpu_valid;
  logic [7:0] kuart_to_cpu       = 8'h00;
  logic       kuart_to_cpu_valid = 1'b0;
  logic       kuart_to_cpu_ready;

  always #5 clk = ~clk;

  sim_kuart_endpoint #(
    .TX_DEPTH(TX_DEPTH),
    .RX_DEPTH(RX_DEPTH),
    .TX_GAP  (TX_GAP)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .tx_data             (tx_data),
    .tx_we               (tx_we),
    .tx_ready            (tx_ready),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_re               (rx_re),
    .rx_dropped          (rx_dropped),
    .kuart_from_cpu      (kuart_from_cpu),
    .kuart_from_cpu_valid(kuart_from_cpu_valid),
    .kuart_to_cpu        (kuart_to_cpu),
    .kuart_to_cpu_valid  (kuart_to_cpu_valid),
    .kuart_to_cpu_ready  (kuart_to_cpu_ready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: byte queues plus the earliest cycle at which the next
  // TX byte may leave (one emission, then TX_GAP silent cycles).
  // ---------------------------------------------------------------------------
  logic [7:0] m_tx_q[$];
  logic [7:0] m_rx_q[$];
  logic [7:0] m_last    = 8'h00;
  logic       m_pulse   = 1'b0;
  logic       m_drop    = 1'b0;
  longint     m_cyc     = 0;
  longint     m_next_ok = 0;

  always @(negedge clk) begin : model_cmp
    logic rxr;
    logic echo;
    logic txr;
    if (!reset_n) begin
      chk1("rst_tx_ready", tx_ready, 1'b1);
      chk1("rst_rx_valid", rx_valid, 1'b0);
      chk1("rst_to_cpu_ready", kuart_to_cpu_ready, 1'b1);
      chk1("rst_from_valid", kuart_from_cpu_valid, 1'b0);
      chk8("rst_from_cpu", kuart_from_cpu, 8'h00);
      chk1("rst_dropped", rx_dropped, 1'b0);
      m_tx_q.delete();
      m_rx_q.delete();
      m_last    = 8'h00;
      m_pulse   = 1'b0;
      m_drop    = 1'b0;
      m_next_ok = 0;
    end else begin
      rxr  = (m_rx_q.size() < RX_DEPTH);
      echo = 1'b0;
`ifdef KUART_ECHO_EN
      rxr  = rxr && (m_tx_q.size() < TX_DEPTH);
      echo = kuart_to_cpu_valid && rxr;
`endif
      txr  = (m_tx_q.size() < TX_DEPTH) && !echo;

      chk1("tx_ready", tx_ready, txr);
      chk1("to_cpu_ready", kuart_to_cpu_ready, rxr);
      chk1("rx_valid", rx_valid, m_rx_q.size() > 0);
      if (m_rx_q.size() > 0) chk8("rx_data", rx_data, m_rx_q[0]);
      chk1("rx_dropped", rx_dropped, m_drop);
      chk1("from_valid", kuart_from_cpu_valid, m_pulse);
      chk8("from_cpu", kuart_from_cpu, m_last);

      if (rx_re && m_rx_q.size() > 0) void'(m_rx_q.pop_front());
      if (kuart_to_cpu_valid) begin
        if (rxr) begin
          m_rx_q.push_back(kuart_to_cpu);
          if (echo) m_tx_q.push_back(kuart_to_cpu);
        end else begin
          m_drop = 1'b1;
        end
      end
      if (tx_we && txr) m_tx_q.push_back(tx_data);

      m_pulse = 1'b0;
      if (m_cyc >= m_next_ok && m_tx_q.size() > 0) begin
        m_last    = m_tx_q.pop_front();
        m_pulse   = 1'b1;
        m_next_ok = m_cyc + TX_GAP + 1;
      end
      m_cyc++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tx_we = 1'b0; rx_re = 1'b0; kuart_to_cpu_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int pct(input int ph, input int which);
    int t [4][3];
    t = '{'{80, 20, 10}, '{10, 80, 20}, '{50, 50, 50}, '{30, 60, 90}};
    return t[ph][which];
  endfunction

  initial begin : driver
    logic [7:0] bytes3 [3];
    int         pulse_at [$];
    logic [7:0] pulse_by [$];
    int         npulse;

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Values straight out of reset.
    chk1("init_tx_ready", tx_ready, 1'b1);
    chk1("init_rx_valid", rx_valid, 1'b0);
    chk1("init_to_cpu_ready", kuart_to_cpu_ready, 1'b1);
    chk8("init_from_cpu", kuart_from_cpu, 8'h00);

    // Single byte: pulse on the next cycle, one cycle wide, value held.
    idle(2);
    tx_data = 8'h41; tx_we = 1'b1;
    step();
    tx_we = 1'b0;
    chk1("b41_valid", kuart_from_cpu_valid, 1'b1);
    chk8("b41_data", kuart_from_cpu, 8'h41);
    step();
    chk1("b41_width", kuart_from_cpu_valid, 1'b0);
    chk8("b41_hold", kuart_from_cpu, 8'h41);

    // Three back-to-back bytes: pulses at +1, +6, +11.
    idle(10);
    bytes3 = '{8'hA1, 8'hB2, 8'hC3};
    tx_data = bytes3[0]; tx_we = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (kuart_from_cpu_valid) begin
        pulse_at.push_back(k);
        pulse_by.push_back(kuart_from_cpu);
      end
      if (k < 3) tx_data = bytes3[k];
      else tx_we = 1'b0;
    end
    chki("burst_npulse", pulse_at.size(), 3);
    if (pulse_at.size() == 3) begin
      chki("burst_t0", pulse_at[0], 1);
      chki("burst_t1", pulse_at[1], 6);
      chki("burst_t2", pulse_at[2], 11);
      chk8("burst_b0", pulse_by[0], 8'hA1);
      chk8("burst_b1", pulse_by[1], 8'hB2);
      chk8("burst_b2", pulse_by[2], 8'hC3);
    end

    // Single-cycle RX pulse, then pop.
    idle(10);
    kuart_to_cpu = 8'h72; kuart_to_cpu_valid = 1'b1;
    step();
    kuart_to_cpu_valid = 1'b0;
    chk1("rx72_valid", rx_valid, 1'b1);
    chk8("rx72_data", rx_data, 8'h72);
    rx_re = 1'b1;
    step();
    rx_re = 1'b0;
    chk1("rx72_popped", rx_valid, 1'b0);

    // Nine RX offers without reads: ninth is refused and dropped.
    idle(20);
    for (int i = 0; i < 9; i++) begin
      kuart_to_cpu = 8'h10 + 8'(i); kuart_to_cpu_valid = 1'b1;
      chk1("rxfill_ready", kuart_to_cpu_ready, i < 8);
      step();
    end
    kuart_to_cpu_valid = 1'b0;
    chk1("rxfill_dropped", rx_dropped, 1'b1);
    chk8("rxfill_head", rx_data, 8'h10);
    rx_re = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk8("rxdrain_data", rx_data, 8'h10 + 8'(j));
      step();
    end
    rx_re = 1'b0;
    chk1("rxdrain_empty", rx_valid, 1'b0);

    // Reset in the middle of a gap with two bytes still queued.
    idle(60);
    tx_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'h50 + 8'(i);
      step();
    end
    tx_we = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk1("midgap_tx_ready", tx_ready, 1'b1);
    chk8("midgap_from_cpu", kuart_from_cpu, 8'h00);
    chk1("midgap_valid", kuart_from_cpu_valid, 1'b0);
    chk1("midgap_dropped", rx_dropped, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (kuart_from_cpu_valid) npulse++;
    end
    chki("midgap_no_pulse", npulse, 0);

`ifdef KUART_ECHO_EN
    // Echo collides with a CPU write: echo wins, CPU byte refused.
    kuart_to_cpu = 8'h2E; kuart_to_cpu_valid = 1'b1;
    tx_data = 8'h55; tx_we = 1'b1;
    #1;
    chk1("echo_tx_ready", tx_ready, 1'b0);
    step();
    kuart_to_cpu_valid = 1'b0; tx_we = 1'b0;
    chk1("echo_valid", kuart_from_cpu_valid, 1'b1);
    chk8("echo_data", kuart_from_cpu, 8'h2E);
    rx_re = 1'b1;
    step();
    rx_re = 1'b0;
    idle(12);
`endif

    // Randomised traffic in four mixes; one reset pulse mid-way.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 700; i++) begin
        tx_we              = ($urandom_range(99) < pct(ph, 0));
        tx_data            = 8'($urandom);
        kuart_to_cpu_valid = ($urandom_range(99) < pct(ph, 1));
        kuart_to_cpu       = 8'($urandom);
        rx_re              = ($urandom_range(99) < pct(ph, 2));
        if (ph == 2 && i == 350) begin
          reset_n = 1'b0;
          step();
          reset_n = 1'b1;
        end
        step();
      end
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_kuart_endpoint.md
SIM_KUART_ENDPOINT -- requirements
Module: sim_kuart_endpoint

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8: TX FIFO entries, power of two, 2..64.
REQ-002 SHALL have parameter RX_DEPTH, default 8: RX FIFO entries, power of two, 2..64.
REQ-003 SHALL have parameter TX_GAP, default 4: idle cycles enforced between emitted TX bytes, 0..255.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 tx_data  input  8  CPU-side byte to send.
REQ-007 tx_we  input  1  CPU write strobe; byte accepted when tx_we && tx_ready.
REQ-008 tx_ready  output  1  TX FIFO can accept a CPU byte this cycle.
REQ-009 rx_data  output  8  head of RX FIFO (first-word fall-through).
REQ-010 rx_valid  output  1  RX FIFO non-empty.
REQ-011 rx_re  input  1  pop RX head; ignored when rx_valid low.
REQ-012 rx_dropped  output  1  sticky: a sim-side byte was offered while not ready.
REQ-013 kuart_from_cpu  output  8  last byte emitted toward the simulation.
REQ-014 kuart_from_cpu_valid  output  1  one-cycle pulse per emitted byte.
REQ-015 kuart_to_cpu  input  8  byte from simulation.
REQ-016 kuart_to_cpu_valid  input  1  simulation byte offered (may be a single-cycle pulse).
REQ-017 kuart_to_cpu_ready  output  1  RX side can accept a byte this cycle.

Function
REQ-018 TX path SHALL be a FIFO of TX_DEPTH bytes with a gap counter (8-bit) and two states: IDLE, GAP.
REQ-019 In IDLE with FIFO non-empty, SHALL pop head, register it onto kuart_from_cpu, pulse kuart_from_cpu_valid next cycle, load counter with TX_GAP, enter GAP (or stay IDLE if TX_GAP==0).
REQ-020 In GAP, counter SHALL decrement each cycle; at 1->0 transition return to IDLE.
REQ-021 Latency: byte written at cycle N into empty FIFO in IDLE SHALL appear with valid at cycle N+1.
REQ-022 kuart_from_cpu SHALL hold its last value between pulses.
REQ-023 tx_ready SHALL be low when TX FIFO holds TX_DEPTH entries; simultaneous write and emit-pop when full SHALL not be accepted (ready is low).
REQ-024 RX path SHALL be a FIFO of RX_DEPTH bytes; push when kuart_to_cpu_valid && kuart_to_cpu_ready.
REQ-025 kuart_to_cpu_ready SHALL be high iff RX FIFO count < RX_DEPTH (plus REQ-033 with echo).
REQ-026 kuart_to_cpu_valid high while kuart_to_cpu_ready low SHALL set rx_dropped; byte discarded.
REQ-027 Simultaneous push and rx_re with FIFO non-empty SHALL push and pop in same cycle, count unchanged.
REQ-028 rx_re on empty FIFO SHALL be ignored; a same-cycle push on empty FIFO SHALL appear on rx_valid next cycle.
REQ-029 FIFO pointers SHALL wrap modulo depth; count SHALL be log2(depth)+1 bits, never exceed depth.

Reset
REQ-030 reset_n low SHALL asynchronously clear: FIFOs empty, state IDLE, counter 0, kuart_from_cpu 8'h00, kuart_from_cpu_valid 0, rx_dropped 0; thus tx_ready 1, rx_valid 0, kuart_to_cpu_ready 1 after release.
REQ-031 Reset mid-GAP or with FIFO contents SHALL discard all pending bytes; no pulse emitted after release until a new write.

Configuration
REQ-032 Macro KUART_ECHO_EN SHALL select echo mode; undefined: no echo, REQ-025 as written.
REQ-033 Defined: every accepted RX byte SHALL also be pushed into TX FIFO; kuart_to_cpu_ready additionally requires TX FIFO not full; tx_ready SHALL be low in any cycle an echo push occurs (echo has priority over CPU).

Verification
REQ-034 Write 8'h41 into idle empty TX at cycle N -> kuart_from_cpu=8'h41, valid pulse at N+1, width 1 cycle.
REQ-035 Write 3 bytes back-to-back, TX_GAP=4 -> valid pulses at N+1, N+6, N+11; bytes in order.
REQ-036 Offer 9 sim bytes with no rx_re, RX_DEPTH=8 -> ready low after 8th, 9th sets rx_dropped, rx_data=first byte.
REQ-037 Single-cycle kuart_to_cpu_valid with 8'h72 -> rx_valid next cycle, rx_data=8'h72; rx_re pops, rx_valid 0.
REQ-038 Assert reset_n low mid-GAP with 2 bytes queued -> no further pulses, tx_ready 1, kuart_from_cpu 8'h00.
REQ-039 With KUART_ECHO_EN, offer 8'h2e concurrently with CPU tx_we -> tx_ready low that cycle, 8'h2e emitted on kuart_from_cpu, CPU byte not accepted.
